// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences ALU, memory, IR, PC and register file writes.
// Outputs decode the current state; a retired-instruction counter tracks completed work.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e           state_q, state_d;
    state_e           dec_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             illegal_dec;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_dec = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d = retire ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While in reset the datapath sees a FETCH decode with every write enable masked.
    assign dec_state = rst_n ? state_q : S_FETCH;

    always_comb begin
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        case (dec_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign illegal_op  = rst_n & illegal_dec;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl with hand-computed per-cycle outputs.
// A narrow counter instance lets the wrap-around case run in a few dozen cycles.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    // {pcw,br,iord,mrd,mwr,irw,m2r,rdst,rw,asa, asb[2], aop[2], pcs[2], ill}
    typedef logic [16:0] ctl_t;

    localparam ctl_t C_RST   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam ctl_t C_FW    = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam ctl_t C_FA    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam ctl_t C_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam ctl_t C_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam ctl_t C_MADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam ctl_t C_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam ctl_t C_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam ctl_t C_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam ctl_t C_EXE   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam ctl_t C_AWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam ctl_t C_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam ctl_t C_AIEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam ctl_t C_AIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam ctl_t C_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic          rst;
        logic [5:0]    op;
        logic          rdy;
        logic [3:0]    st;
        ctl_t          ctl;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;
    int row   = 0;
    vec_t tbl[$];

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite),
        .Branch(Branch),
        .IorD(IorD),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .MemtoReg(MemtoReg),
        .RegDst(RegDst),
        .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp),
        .PCSrc(PCSrc),
        .state(state),
        .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic vec_t v(input logic r, input logic [5:0] o,
                               input logic rd, input logic [3:0] s,
                               input ctl_t c, input logic [CW-1:0] n);
        vec_t x;
        x.rst = r;
        x.op  = o;
        x.rdy = rd;
        x.st  = s;
        x.ctl = c;
        x.cnt = n;
        return x;
    endfunction

    task automatic step(input vec_t x);
        ctl_t got;
        @(negedge clk);
        rst_n     = x.rst;
        opcode    = x.op;
        mem_ready = x.rdy;
        #1;
        got = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};
        n_cmp += 3;
        if (got !== x.ctl) begin
            n_err++;
            $display("FAIL ctl row %0d: got %b want %b", row, got, x.ctl);
        end
        if (state !== x.st) begin
            n_err++;
            $display("FAIL state row %0d: got %0d want %0d", row, state, x.st);
        end
        if (instr_count !== x.cnt) begin
            n_err++;
            $display("FAIL count row %0d: got %0d want %0d",
                     row, instr_count, x.cnt);
        end
        row++;
    endtask

    initial begin
        // reset (write enables masked even with mem_ready high), then R-type
        tbl.push_back(v(0, OP_R,    1, 0,  C_RST,  0));
        tbl.push_back(v(1, OP_R,    1, 0,  C_FA,   0));
        tbl.push_back(v(1, OP_R,    1, 1,  C_DEC,  0));
        tbl.push_back(v(1, OP_R,    1, 6,  C_EXE,  0));
        tbl.push_back(v(1, OP_R,    1, 7,  C_AWB,  0));
        // lw with two wait cycles in MEMRD
        tbl.push_back(v(1, OP_LW,   1, 0,  C_FA,   1));
        tbl.push_back(v(1, OP_LW,   1, 1,  C_DEC,  1));
        tbl.push_back(v(1, OP_LW,   1, 2,  C_MADR, 1));
        tbl.push_back(v(1, OP_LW,   0, 3,  C_MRD,  1));
        tbl.push_back(v(1, OP_LW,   0, 3,  C_MRD,  1));
        tbl.push_back(v(1, OP_LW,   1, 3,  C_MRD,  1));
        tbl.push_back(v(1, OP_LW,   1, 4,  C_MWB,  1));
        // sw with a fetch wait and three wait cycles in MEMWR
        tbl.push_back(v(1, OP_SW,   0, 0,  C_FW,   2));
        tbl.push_back(v(1, OP_SW,   1, 0,  C_FA,   2));
        tbl.push_back(v(1, OP_SW,   1, 1,  C_DEC,  2));
        tbl.push_back(v(1, OP_SW,   1, 2,  C_MADR, 2));
        tbl.push_back(v(1, OP_SW,   0, 5,  C_MWR,  2));
        tbl.push_back(v(1, OP_SW,   0, 5,  C_MWR,  2));
        tbl.push_back(v(1, OP_SW,   0, 5,  C_MWR,  2));
        tbl.push_back(v(1, OP_SW,   1, 5,  C_MWR,  2));
        // beq, j, addi
        tbl.push_back(v(1, OP_BEQ,  1, 0,  C_FA,   3));
        tbl.push_back(v(1, OP_BEQ,  1, 1,  C_DEC,  3));
        tbl.push_back(v(1, OP_BEQ,  1, 8,  C_BR,   3));
        tbl.push_back(v(1, OP_J,    1, 0,  C_FA,   4));
        tbl.push_back(v(1, OP_J,    1, 1,  C_DEC,  4));
        tbl.push_back(v(1, OP_J,    1, 11, C_JMP,  4));
        tbl.push_back(v(1, OP_ADDI, 1, 0,  C_FA,   5));
        tbl.push_back(v(1, OP_ADDI, 1, 1,  C_DEC,  5));
        tbl.push_back(v(1, OP_ADDI, 1, 9,  C_AIEX, 5));
        tbl.push_back(v(1, OP_ADDI, 1, 10, C_AIWB, 5));
        // illegal opcode: pulse in DECODE, back to FETCH, not counted
        tbl.push_back(v(1, OP_BAD,  1, 0,  C_FA,   6));
        tbl.push_back(v(1, OP_BAD,  1, 1,  C_ILL,  6));
        // R-type aborted by reset while in ALUWB
        tbl.push_back(v(1, OP_R,    1, 0,  C_FA,   6));
        tbl.push_back(v(1, OP_R,    1, 1,  C_DEC,  6));
        tbl.push_back(v(1, OP_R,    1, 6,  C_EXE,  6));
        tbl.push_back(v(0, OP_R,    1, 7,  C_RST,  6));
        tbl.push_back(v(1, OP_J,    1, 0,  C_FA,   0));

        rst_n     = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) step(tbl[i]);

        // counter wrap: that j plus fifteen more bring the count to 2^CW
        step(v(1, OP_J, 1, 1,  C_DEC, 0));
        step(v(1, OP_J, 1, 11, C_JMP, 0));
        for (int i = 1; i < 16; i++) begin
            step(v(1, OP_J, 1, 0,  C_FA,  CW'(i)));
            step(v(1, OP_J, 1, 1,  C_DEC, CW'(i)));
            step(v(1, OP_J, 1, 11, C_JMP, CW'(i)));
        end
        step(v(1, OP_SW, 1, 0, C_FA, 0));

        // sw aborted by reset on the very edge memory acknowledges
        step(v(1, OP_SW, 1, 1, C_DEC,  0));
        step(v(1, OP_SW, 1, 2, C_MADR, 0));
        step(v(1, OP_SW, 0, 5, C_MWR,  0));
        step(v(0, OP_SW, 1, 5, C_RST,  0));
        step(v(1, OP_SW, 0, 0, C_FW,   0));

        // one retired j after reset, then abort a store so the count returns to zero
        step(v(1, OP_J,  1, 0,  C_FA,   0));
        step(v(1, OP_J,  1, 1,  C_DEC,  0));
        step(v(1, OP_J,  1, 11, C_JMP,  0));
        step(v(1, OP_SW, 1, 0,  C_FA,   1));
        step(v(1, OP_SW, 1, 1,  C_DEC,  1));
        step(v(1, OP_SW, 1, 2,  C_MADR, 1));
        step(v(0, OP_SW, 1, 5,  C_RST,  1));
        step(v(1, OP_SW, 0, 0,  C_FW,   0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
